// File: rtl/menu_nav.sv
// Front-panel menu navigator: page wrap on left/right, per-page inc/dec pulses with auto-repeat, idle return home.
// Latency: one cycle from button sample to registered page/inc/dec/timeout_evt.
// Backpressure: none; pulses are single-cycle and consumers must take them when presented.
module menu_nav #(
    parameter int  N_PAGES        = 4,
    parameter int  HOME_PAGE      = 0,
    parameter int  HOLD_CYCLES    = 50000000,
    parameter int  REPEAT_CYCLES  = 10000000,
    parameter int  TIMEOUT_CYCLES = 1500000000,
    localparam int PAGE_W         = $clog2(N_PAGES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    output logic [PAGE_W-1:0]  page,
    output logic [N_PAGES-1:0] inc,
    output logic [N_PAGES-1:0] dec,
    output logic               timeout_evt
);

    localparam int CNT_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDLE_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int IDLE_W   = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
    localparam logic [PAGE_W-1:0] HOME = PAGE_W'(HOME_PAGE);
    localparam logic [PAGE_W-1:0] LAST = PAGE_W'(N_PAGES - 1);

    logic [3:0]         btn, btn_edge, btn_prev_q, btn_prev_d;
    logic [PAGE_W-1:0]  page_q, page_d;
    logic [N_PAGES-1:0] inc_q, inc_d, dec_q, dec_d;
    logic               tevt_q, tevt_d;
    logic               hold_act_q, hold_act_d, hold_dn_q, hold_dn_d, rep_q, rep_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               nav_edge, to_fire, held_lvl, rep_hit, do_inc, do_dec;

    assign btn      = {right, left, down, up};
    assign btn_edge = btn & ~btn_prev_q;
    assign nav_edge = btn_edge[3] | btn_edge[2];
    assign held_lvl = hold_dn_q ? down : up;
    assign rep_hit  = rep_q ? (hold_cnt_q == CNT_W'(REPEAT_CYCLES))
                            : (hold_cnt_q == CNT_W'(HOLD_CYCLES));
    // A press in the firing cycle wins over the timeout.
    assign to_fire  = (TIMEOUT_CYCLES > 0) && (idle_q == IDLE_W'(IDLE_MAX)) &&
                      (page_q != HOME) && (btn_edge == 4'b0000);

    always_comb begin
        btn_prev_d = btn;
        page_d     = page_q;
        tevt_d     = to_fire;
        if (to_fire) begin
            page_d = HOME;
        end else if (btn_edge[3] && !btn_edge[2]) begin
            page_d = (page_q == LAST) ? '0 : page_q + PAGE_W'(1);
        end else if (btn_edge[2] && !btn_edge[3]) begin
            page_d = (page_q == '0) ? LAST : page_q - PAGE_W'(1);
        end
    end

    // Hold tracking: phase 0 waits HOLD_CYCLES after the press, phase 1 paces repeats.
    always_comb begin
        hold_act_d = hold_act_q;
        hold_dn_d  = hold_dn_q;
        rep_d      = rep_q;
        hold_cnt_d = hold_cnt_q;
        do_inc     = 1'b0;
        do_dec     = 1'b0;
        if (nav_edge || (up && down)) begin
            hold_act_d = 1'b0;
            rep_d      = 1'b0;
            hold_cnt_d = '0;
        end else if (btn_edge[0] || btn_edge[1]) begin
            do_inc     = btn_edge[0];
            do_dec     = btn_edge[1];
            hold_act_d = 1'b1;
            hold_dn_d  = btn_edge[1];
            rep_d      = 1'b0;
            hold_cnt_d = CNT_W'(1);
        end else if (hold_act_q && held_lvl) begin
            if (rep_hit) begin
                do_inc     = !hold_dn_q;
                do_dec     = hold_dn_q;
                rep_d      = 1'b1;
                hold_cnt_d = CNT_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else begin
            hold_act_d = 1'b0;
            rep_d      = 1'b0;
            hold_cnt_d = '0;
        end
    end

    always_comb begin
        inc_d = '0;
        dec_d = '0;
        for (int p = 0; p < N_PAGES; p++) begin
            inc_d[p] = do_inc && (page_q == PAGE_W'(p));
            dec_d[p] = do_dec && (page_q == PAGE_W'(p));
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (btn != 4'b0000) begin
            idle_d = '0;
        end else if (idle_q != IDLE_W'(IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            page_q     <= HOME;
            inc_q      <= '0;
            dec_q      <= '0;
            tevt_q     <= 1'b0;
            hold_act_q <= 1'b0;
            hold_dn_q  <= 1'b0;
            rep_q      <= 1'b0;
            hold_cnt_q <= '0;
            idle_q     <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            page_q     <= page_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            tevt_q     <= tevt_d;
            hold_act_q <= hold_act_d;
            hold_dn_q  <= hold_dn_d;
            rep_q      <= rep_d;
            hold_cnt_q <= hold_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign page        = page_q;
    assign inc         = inc_q;
    assign dec         = dec_q;
    assign timeout_evt = tevt_q;

endmodule
